// File: rtl/alu_ctrl_decode_pkg.sv
// Shared definitions for the ID-stage decoder: ALU select codes (the same
// encoding the execute-stage ALU decodes), RV32 opcode/funct7 constants,
// immediate format selector and the registered control bundle.
package alu_ctrl_decode_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_MUL = 4'b1000,
    ALU_DIV = 4'b1001
  } alu_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // IMM_LINK yields the constant 4 used as the link-address increment.
  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_SHAMT, IMM_S, IMM_B, IMM_U, IMM_J, IMM_LINK
  } imm_fmt_e;

  typedef struct packed {
    alu_sel_e    alu;
    logic        opa_pc;
    logic        opb_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode_imm_gen.sv
// Immediate extraction and sign extension for the RV32 I/S/B/U/J formats.
// Ports:
//   instr  in  instruction bits [31:7] (opcode not needed here)
//   fmt    in  immediate format to produce
//   imm    out 32-bit immediate; shift amounts are zero-extended
module alu_ctrl_decode_imm_gen
  import alu_ctrl_decode_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
      IMM_SHAMT: imm = {27'b0, instr[24:20]};
      IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:     imm = {instr[31:12], 12'b0};
      IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      IMM_LINK:  imm = 32'd4;
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// RV32IM ID-stage decoder with a registered ID/EX bundle.
// Ports:
//   CLK, RESET (sync, active low)
//   IN_VALID/IN_READY, INSTR, PC  : fetch side handshake
//   FLUSH                         : drop registered and presented instruction
//   OUT_VALID/OUT_READY           : execute side handshake
//   ALU_SELECT, OPA_PC, OPB_IMM, IMM, RS1, RS2, RD, REG_WRITE, MEM_READ,
//   MEM_WRITE, BRANCH, ILLEGAL, PC_OUT : registered decoded bundle
// A MUL/DIV holds IN_READY low for LATENCY-1 cycles after it is accepted so
// the ALU is not handed a new op while it is still iterating.
module alu_ctrl_decode
  import alu_ctrl_decode_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTR,
  input  logic [31:0] PC,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [3:0]  ALU_SELECT,
  output logic        OPA_PC,
  output logic        OPB_IMM,
  output logic [31:0] IMM,
  output logic [4:0]  RS1,
  output logic [4:0]  RS2,
  output logic [4:0]  RD,
  output logic        REG_WRITE,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        BRANCH,
  output logic        ILLEGAL,
  output logic [31:0] PC_OUT
);

  localparam int MAXL = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int BW   = (MAXL > 2) ? $clog2(MAXL) : 1;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = INSTR[6:0];
  assign f3  = INSTR[14:12];
  assign f7  = INSTR[31:25];

  ctrl_t       d, q;
  imm_fmt_e    fmt;
  logic [31:0] imm, imm_q, pc_q;
  logic        vld;
  logic [BW-1:0] busy;
  logic        accept;

  alu_ctrl_decode_imm_gen u_imm (.instr(INSTR[31:7]), .fmt(fmt), .imm(imm));

  always_comb begin
    d         = '0;
    d.alu     = ALU_ADD;
    d.rs1     = INSTR[19:15];
    d.rs2     = INSTR[24:20];
    d.rd      = INSTR[11:7];
    fmt       = IMM_NONE;
    d.illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        d.reg_write = 1'b1;
        case ({f7, f3})
          {F7_BASE,   3'b000}: d.alu = ALU_ADD;
          {F7_BASE,   3'b111}: d.alu = ALU_AND;
          {F7_BASE,   3'b110}: d.alu = ALU_OR;
          {F7_BASE,   3'b100}: d.alu = ALU_XOR;
          {F7_BASE,   3'b001}: d.alu = ALU_SLL;
          {F7_BASE,   3'b101}: d.alu = ALU_SRL;
          {F7_ALT,    3'b000}: d.alu = ALU_SUB;
          {F7_ALT,    3'b101}: d.alu = ALU_SRA;
          {F7_MULDIV, 3'b000}: d.alu = ALU_MUL;
          {F7_MULDIV, 3'b100}: d.alu = ALU_DIV;
          default:             d.illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        d.opb_imm   = 1'b1;
        d.reg_write = 1'b1;
        fmt         = IMM_I;
        case (f3)
          3'b000: d.alu = ALU_ADD;
          3'b111: d.alu = ALU_AND;
          3'b110: d.alu = ALU_OR;
          3'b100: d.alu = ALU_XOR;
          3'b001: begin
            d.alu = ALU_SLL;
            fmt   = IMM_SHAMT;
            if (f7 != F7_BASE) d.illegal = 1'b1;
          end
          3'b101: begin
            fmt = IMM_SHAMT;
            if (f7 == F7_BASE)     d.alu = ALU_SRL;
            else if (f7 == F7_ALT) d.alu = ALU_SRA;
            else                   d.illegal = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.opb_imm = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1; fmt = IMM_I;
      end
      OPC_STORE: begin
        d.opb_imm = 1'b1; d.mem_write = 1'b1; d.rd = '0; fmt = IMM_S;
      end
      OPC_BRANCH: begin
        d.alu = ALU_SUB; d.branch = 1'b1; d.rd = '0; fmt = IMM_B;
        if (f3[2:1] != 2'b00) d.illegal = 1'b1;
      end
      OPC_LUI: begin
        d.rs1 = '0; d.opb_imm = 1'b1; d.reg_write = 1'b1; fmt = IMM_U;
      end
      OPC_AUIPC: begin
        d.opa_pc = 1'b1; d.opb_imm = 1'b1; d.reg_write = 1'b1; fmt = IMM_U;
      end
      OPC_JAL, OPC_JALR: begin
        // only the link value is produced here; the jump target is elsewhere
        d.opa_pc = 1'b1; d.opb_imm = 1'b1; d.reg_write = 1'b1; fmt = IMM_LINK;
        if (opc == OPC_JALR && f3 != 3'b000) d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // illegal bundles still issue (for the trap path) but must do nothing
    if (d.illegal) begin
      d.alu = ALU_AND; d.opa_pc = 1'b0; d.opb_imm = 1'b0; d.reg_write = 1'b0;
      d.mem_read = 1'b0; d.mem_write = 1'b0; d.branch = 1'b0; fmt = IMM_NONE;
    end
    if (d.rd == 5'd0) d.reg_write = 1'b0;
  end

  assign IN_READY = RESET & (~vld | OUT_READY) & (busy == '0);
  assign accept   = IN_VALID & IN_READY & ~FLUSH;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      q     <= '0;
      imm_q <= '0;
      pc_q  <= '0;
      vld   <= 1'b0;
      busy  <= '0;
    end else if (FLUSH) begin
      vld  <= 1'b0;
      busy <= '0;
    end else begin
      if (busy != '0) busy <= busy - BW'(1);
      if (accept) begin
        q     <= d;
        imm_q <= imm;
        pc_q  <= PC;
        vld   <= 1'b1;
        // accept implies busy==0, so this load never races the decrement
        if (d.alu == ALU_MUL)      busy <= BW'(MUL_LATENCY - 1);
        else if (d.alu == ALU_DIV) busy <= BW'(DIV_LATENCY - 1);
      end else if (OUT_READY) begin
        vld <= 1'b0;
      end
    end
  end

  assign OUT_VALID  = vld;
  assign ALU_SELECT = q.alu;
  assign OPA_PC     = q.opa_pc;
  assign OPB_IMM    = q.opb_imm;
  assign IMM        = imm_q;
  assign RS1        = q.rs1;
  assign RS2        = q.rs2;
  assign RD         = q.rd;
  assign REG_WRITE  = q.reg_write;
  assign MEM_READ   = q.mem_read;
  assign MEM_WRITE  = q.mem_write;
  assign BRANCH     = q.branch;
  assign ILLEGAL    = q.illegal;
  assign PC_OUT     = pc_q;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: directed scenarios followed by random traffic.
// Instructions are assembled from mnemonics with known field/immediate
// values, so expectations come from the assembler side, not from decoding.
module tb_alu_ctrl_decode;

  localparam int MUL_LAT = 1;
  localparam int DIV_LAT = 4;
  localparam int NK      = 35;

  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, FLUSH, OUT_READY;
  logic [31:0] INSTR, PC;
  logic        IN_READY, OUT_VALID, OPA_PC, OPB_IMM;
  logic [3:0]  ALU_SELECT;
  logic [31:0] IMM, PC_OUT;
  logic [4:0]  RS1, RS2, RD;
  logic        REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, ILLEGAL;

  alu_ctrl_decode #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .PC(PC), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ALU_SELECT(ALU_SELECT), .OPA_PC(OPA_PC),
    .OPB_IMM(OPB_IMM), .IMM(IMM), .RS1(RS1), .RS2(RS2), .RD(RD),
    .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .BRANCH(BRANCH), .ILLEGAL(ILLEGAL), .PC_OUT(PC_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  alu;
    logic        opa, opb;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, br, ill;
    logic        k_rs1, k_rs2, k_rd, k_imm;
    logic [3:0]  lat;
    logic [31:0] pc;
  } exp_t;

  // R-type: ADD AND OR XOR SLL SRL SUB SRA MUL DIV
  int r_f7  [10] = '{0, 0, 0, 0, 0, 0, 32, 32, 1, 1};
  int r_f3  [10] = '{0, 7, 6, 4, 1, 5, 0, 5, 0, 4};
  int r_alu [10] = '{2, 0, 1, 3, 4, 5, 6, 7, 8, 9};
  // I-type ALU (10..13): ADDI ANDI ORI XORI; shifts (14..16): SLLI SRLI SRAI
  int i_f3  [4]  = '{0, 7, 6, 4};
  int i_alu [4]  = '{2, 0, 1, 3};
  int s_f7  [3]  = '{0, 0, 32};
  int s_f3  [3]  = '{1, 5, 5};
  int s_alu [3]  = '{4, 5, 7};
  int ld_f3 [5]  = '{0, 1, 2, 4, 5};

  int   checks = 0;
  int   failures = 0;
  exp_t pend[$];
  int   stall = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Assemble instruction of kind k; imm_raw is interpreted per format.
  task automatic gen(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input int imm_raw,
                     output logic [31:0] ins, output exp_t e);
    int v;
    logic [31:0] vb, r;
    logic [19:0] u;
    logic [4:0]  sh;
    int idx;
    r  = $urandom;
    v  = ((imm_raw % 4096) + 4096) % 4096;
    if (v >= 2048) v -= 4096;
    sh = 5'(((imm_raw % 32) + 32) % 32);
    u  = 20'(imm_raw);
    e  = '0;
    e.lat = 4'd1; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.k_rd = 1'b1;
    ins = '0;
    if (k < 10) begin
      ins = {7'(r_f7[k]), rs2, rs1, 3'(r_f3[k]), rd, 7'b0110011};
      e.alu = 4'(r_alu[k]); e.rw = 1'b1; e.k_rs1 = 1'b1; e.k_rs2 = 1'b1;
      if (k == 8) e.lat = 4'(MUL_LAT);
      if (k == 9) e.lat = 4'(DIV_LAT);
    end else if (k < 14) begin
      idx = k - 10; vb = 32'(v);
      ins = {vb[11:0], rs1, 3'(i_f3[idx]), rd, 7'b0010011};
      e.alu = 4'(i_alu[idx]); e.opb = 1'b1; e.rw = 1'b1; e.imm = 32'(v);
      e.k_imm = 1'b1; e.k_rs1 = 1'b1;
    end else if (k < 17) begin
      idx = k - 14;
      ins = {7'(s_f7[idx]), sh, rs1, 3'(s_f3[idx]), rd, 7'b0010011};
      e.alu = 4'(s_alu[idx]); e.opb = 1'b1; e.rw = 1'b1; e.imm = 32'(sh);
      e.k_imm = 1'b1; e.k_rs1 = 1'b1;
    end else if (k == 17) begin
      vb = 32'(v);
      ins = {vb[11:0], rs1, 3'(ld_f3[r % 5]), rd, 7'b0000011};
      e.alu = 4'd2; e.opb = 1'b1; e.mr = 1'b1; e.rw = 1'b1; e.imm = 32'(v);
      e.k_imm = 1'b1; e.k_rs1 = 1'b1;
    end else if (k == 18) begin
      vb = 32'(v);
      ins = {vb[11:5], rs2, rs1, 3'(r % 3), vb[4:0], 7'b0100011};
      e.alu = 4'd2; e.opb = 1'b1; e.mw = 1'b1; e.imm = 32'(v); e.rd = 5'd0;
      e.k_imm = 1'b1; e.k_rs1 = 1'b1; e.k_rs2 = 1'b1;
    end else if (k == 19) begin
      v = 2 * v; vb = 32'(v);
      ins = {vb[12], vb[10:5], rs2, rs1, 2'b00, r[0], vb[4:1], vb[11], 7'b1100011};
      e.alu = 4'd6; e.br = 1'b1; e.imm = 32'(v); e.rd = 5'd0;
      e.k_imm = 1'b1; e.k_rs1 = 1'b1; e.k_rs2 = 1'b1;
    end else if (k == 20 || k == 21) begin
      ins = {u, rd, (k == 20) ? 7'b0110111 : 7'b0010111};
      e.alu = 4'd2; e.opb = 1'b1; e.rw = 1'b1; e.imm = 32'(u) * 32'd4096;
      e.k_imm = 1'b1; e.opa = (k == 21);
      if (k == 20) begin e.rs1 = 5'd0; e.k_rs1 = 1'b1; end
    end else if (k == 22 || k == 23) begin
      ins = (k == 22) ? {r[31:12], rd, 7'b1101111}
                      : {r[31:20], rs1, 3'b000, rd, 7'b1100111};
      e.alu = 4'd2; e.opa = 1'b1; e.opb = 1'b1; e.rw = 1'b1; e.imm = 32'd4;
      e.k_imm = 1'b1; e.k_rs1 = (k == 23);
    end else begin
      case (k)
        24: ins = {7'h00, rs2, rs1, 3'b010, rd, 7'b0110011};
        25: ins = {7'h00, rs2, rs1, 3'b011, rd, 7'b0110011};
        26: ins = {7'h01, rs2, rs1, 3'b001, rd, 7'b0110011};
        27: ins = {7'h01, rs2, rs1, 3'b101, rd, 7'b0110011};
        28: ins = {7'h01, rs2, rs1, 3'b110, rd, 7'b0110011};
        29: ins = {r[11:0], rs1, 3'b010, rd, 7'b0010011};
        30: ins = {r[31:25], rs2, rs1, 3'b100, r[11:7], 7'b1100011};
        31: ins = {r[31:20], rs1, 3'b001, rd, 7'b1100111};
        32: ins = {7'b0100000, sh, rs1, 3'b001, rd, 7'b0010011};
        33: ins = {r[31:7], 7'b0000000};
        default: ins = {r[31:7], 7'b1111111};
      endcase
      e.ill = 1'b1; e.k_rd = 1'b0;
    end
    if (e.rd == 5'd0) e.rw = 1'b0;
  endtask

  task automatic check_out(input exp_t e);
    chk("alu_select", ALU_SELECT, e.alu);
    chk("opa_pc", OPA_PC, e.opa);
    chk("opb_imm", OPB_IMM, e.opb);
    chk("reg_write", REG_WRITE, e.rw);
    chk("mem_read", MEM_READ, e.mr);
    chk("mem_write", MEM_WRITE, e.mw);
    chk("branch", BRANCH, e.br);
    chk("illegal", ILLEGAL, e.ill);
    chk("pc_out", PC_OUT, e.pc);
    if (e.k_imm) chk("imm", IMM, e.imm);
    if (e.k_rs1) chk("rs1", RS1, e.rs1);
    if (e.k_rs2) chk("rs2", RS2, e.rs2);
    if (e.k_rd)  chk("rd", RD, e.rd);
  endtask

  // One clock cycle: drive, check IN_READY, clock, update model, check bundle.
  task automatic step(input bit v, input logic [31:0] ins, input exp_t e,
                      input bit fl, input bit ordy);
    bit exp_rdy, cons;
    e.pc = $urandom & 32'hFFFF_FFFC;
    IN_VALID = v; INSTR = ins; PC = e.pc; FLUSH = fl; OUT_READY = ordy;
    #1;
    exp_rdy = (pend.size() == 0 || ordy) && stall == 0;
    chk("in_ready", IN_READY, exp_rdy);
    last_acc = v && exp_rdy && !fl;
    cons = pend.size() != 0 && ordy;
    @(posedge CLK); #1;
    if (fl) begin
      pend.delete(); stall = 0;
    end else begin
      if (stall > 0) stall--;
      if (cons) void'(pend.pop_front());
      if (last_acc) begin pend.push_back(e); stall = int'(e.lat) - 1; end
    end
    chk("out_valid", OUT_VALID, pend.size() != 0);
    if (pend.size() != 0) check_out(pend[0]);
  endtask

  initial begin
    logic [31:0] ins;
    exp_t e, ea;
    int n;
    RESET = 1'b0; IN_VALID = 1'b1; INSTR = 32'h002081B3; PC = 32'h100;
    FLUSH = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", IN_READY, 1'b0);
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_alu", ALU_SELECT, 4'd0);
    chk("rst_imm", IMM, 32'd0);
    chk("rst_pc_out", PC_OUT, 32'd0);
    chk("rst_regs", {RS1, RS2, RD}, 15'd0);
    chk("rst_flags", {OPA_PC, OPB_IMM, REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, ILLEGAL}, 7'd0);
    RESET = 1'b1; IN_VALID = 1'b0;
    #1;
    chk("rel_in_ready", IN_READY, 1'b1);
    @(posedge CLK); #1;

    // add x3,x1,x2 / addi x5,x0,-1 / srai x1,x1,3
    gen(0, 5'd3, 5'd1, 5'd2, 0, ins, e);   step(1, 32'h002081B3, e, 0, 1);
    gen(10, 5'd5, 5'd0, 5'd0, -1, ins, e); step(1, 32'hFFF00293, e, 0, 1);
    gen(16, 5'd1, 5'd1, 5'd0, 3, ins, e);  step(1, 32'h4030D093, e, 0, 1);

    // backpressure: 5 stalled cycles then release
    gen(0, 5'd3, 5'd1, 5'd2, 0, ins, e);   step(1, 32'h002081B3, e, 0, 1);
    gen(10, 5'd5, 5'd0, 5'd0, -1, ins, e);
    repeat (5) step(1, 32'hFFF00293, e, 0, 0);
    step(1, 32'hFFF00293, e, 0, 1);
    step(0, 32'h0, e, 0, 1);

    // div x4,x1,x2: count refused cycles
    gen(9, 5'd4, 5'd1, 5'd2, 0, ins, e);   step(1, 32'h0220C233, e, 0, 1);
    gen(0, 5'd3, 5'd1, 5'd2, 0, ins, ea);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h002081B3, ea, 0, 1);
      if (last_acc) break;
      n++;
    end
    chk("div_stall_cycles", n, DIV_LAT - 1);
    step(0, 32'h0, ea, 0, 1);

    // div again, flush in the 2nd cycle
    step(1, 32'h0220C233, e, 0, 1);
    step(1, 32'h002081B3, ea, 0, 0);
    step(1, 32'h002081B3, ea, 1, 0);
    chk("flush_out_valid", OUT_VALID, 1'b0);
    chk("flush_in_ready", IN_READY, 1'b1);
    step(0, 32'h0, ea, 0, 1);

    // illegal: all-zero word and slt
    gen(33, 5'd0, 5'd0, 5'd0, 0, ins, e);  step(1, 32'h00000000, e, 0, 1);
    gen(24, 5'd3, 5'd1, 5'd2, 0, ins, e);  step(1, 32'h0020A1B3, e, 0, 1);
    step(0, 32'h0, e, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      gen($urandom_range(0, NK - 1), 5'($urandom), 5'($urandom), 5'($urandom),
          int'($urandom), ins, e);
      step($urandom_range(0, 3) != 0, ins, e, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
